dmem_sram_slave: RTL

//  Responder end of the core's data-SRAM port: services data_sram_en/wen/addr/wdata, returns data_sram_rdata.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/sram_byte_ram.sv | 22 ++
 rtl/dmem_sram_slave.sv | 81 ++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MMIO map constants and byte-merge helper for the data SRAM responder
package dmem_pkg;

    localparam logic [15:0] MMIO_TAG_DEF = 16'h1FAF;
    localparam logic [15:0] OFF_LED      = 16'h0000;
    localparam logic [15:0] OFF_SWITCH   = 16'h0004;
    localparam logic [15:0] OFF_CNT      = 16'h0008;
    localparam logic [15:0] OFF_CMP      = 16'h000C;
    localparam logic [15:0] OFF_STATUS   = 16'h0010;

    function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/sram_byte_ram.sv
// sram_byte_ram: single-port 32-bit RAM with per-byte write lanes and read-first registered output
module sram_byte_ram #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**ADDR_W];

    // read the old word and merge enabled lanes in the same cycle (read-first)
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 4; i++)
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end
endmodule

// File: rtl/dmem_sram_slave.sv
// dmem_sram_slave: data-SRAM port responder with byte-writable RAM and an LED/switch/timer MMIO window
module dmem_sram_slave
    import dmem_pkg::*;
#(
    parameter int          ADDR_W   = 11,
    parameter logic [15:0] MMIO_TAG = MMIO_TAG_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic        timer_irq
);
    logic        mmio_sel, ram_en, wr, hit, w1c, pend, sel_q, unused;
    logic [15:0] off;
    logic [31:0] ram_rdata, mmio_rdata, mmio_q, cnt, cmp, led_new, cnt_new, cmp_new;
    logic [7:0]  sw_meta, sw_sync;

    assign mmio_sel = data_sram_addr[31:16] == MMIO_TAG;
    assign off      = {data_sram_addr[15:2], 2'b00};
    assign ram_en   = data_sram_en & ~mmio_sel & ~rst;
    assign wr       = data_sram_en & mmio_sel & (|data_sram_wen);
    assign hit      = cnt == cmp;
    assign w1c      = wr & (off == OFF_STATUS) & data_sram_wen[0] & data_sram_wdata[0];
    assign unused   = ^{data_sram_addr[1:0], led_new[31:16]};

    sram_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (data_sram_wen),
        .addr  (data_sram_addr[ADDR_W+1:2]),
        .wdata (data_sram_wdata),
        .rdata (ram_rdata)
    );

    // MMIO read value (pre-write) and byte-merged candidates for the writable registers
    always_comb begin
        mmio_rdata = off == OFF_LED    ? {16'h0, led} :
                     off == OFF_SWITCH ? {24'h0, sw_sync} :
                     off == OFF_CNT    ? cnt :
                     off == OFF_CMP    ? cmp :
                     off == OFF_STATUS ? {31'h0, pend} : 32'h0;
        led_new = apply_be({16'h0, led}, data_sram_wdata, data_sram_wen);
        cnt_new = apply_be(cnt, data_sram_wdata, data_sram_wen);
        cmp_new = apply_be(cmp, data_sram_wdata, data_sram_wen);
    end

    // MMIO registers, timer, switch synchroniser and the registered read steering
    always_ff @(posedge clk) begin
        if (rst) begin
            led       <= '0;
            cnt       <= '0;
            cmp       <= '1;
            pend      <= 1'b0;
            timer_irq <= 1'b0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            sel_q     <= 1'b1;
            mmio_q    <= '0;
        end else begin
            sw_meta   <= switch;
            sw_sync   <= sw_meta;
            cnt       <= (wr && off == OFF_CNT) ? cnt_new : cnt + 32'd1;
            if (wr && off == OFF_LED) led <= led_new[15:0];
            if (wr && off == OFF_CMP) cmp <= cmp_new;
            pend      <= hit | (pend & ~w1c);
            timer_irq <= pend;
            if (data_sram_en) begin
                sel_q  <= mmio_sel;
                mmio_q <= mmio_rdata;
            end
        end
    end

    assign data_sram_rdata = sel_q ? mmio_q : ram_rdata;
endmodule
